// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state enum, default width and counter-width helper
// for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_WIDTH_DEF = 16;

  function automatic int sa_cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: 1-bit full-adder cell used as the serial bit slice.
// Ports: a, b, ci in; s (sum), co (carry) out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder, one bit per cycle through a full_adder slice.
// Ports: clk, rst_n, start, A, B, Cin in; busy, done, Sum, Cout, Ofl out.
// Ofl is built only when SERIAL_ADDER_OFL_EN is defined, else tied to 0.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ofl
);

  localparam int CW = sa_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             cy;
  logic             fs, fc;
  logic             last, load, run;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cy),
    .s  (fs),
    .co (fc)
  );

  assign run  = (state == RUN);
  assign last = (cnt == LAST);
  // start is only honoured when no add is in flight
  assign load = start && !run;

  assign busy = run;
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      Sum  <= '0;
      Cout <= 1'b0;
    end else if (load) begin
      a_sh <= A;
      b_sh <= B;
      cy   <= Cin;
      cnt  <= '0;
    end else if (run) begin
      s_sh <= {fs, s_sh[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cy   <= fc;
      cnt  <= cnt + CW'(1);
      if (last) begin
        Sum  <= {fs, s_sh[WIDTH-1:1]};
        Cout <= fc;
      end
    end
  end

`ifdef SERIAL_ADDER_OFL_EN
  // on the last bit, cy is the carry into the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           Ofl <= 1'b0;
    else if (run && last) Ofl <= cy ^ fc;
  end
`else
  assign Ofl = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder.
// Covers reset, add, carry/overflow, Cin, stability, back-to-back, abort.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A, B;
  logic        Cin;
  logic        busy, done;
  logic [15:0] Sum;
  logic        Cout, Ofl;

  int vectors;
  int miscompares;

`ifdef SERIAL_ADDER_OFL_EN
  localparam logic OFL_ON = 1'b1;
`else
  localparam logic OFL_ON = 1'b0;
`endif

  serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ofl   (Ofl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic ci);
    @(negedge clk);
    A = a; B = b; Cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_basic();
    int n, bsy, both;
    n = 0; bsy = 0; both = 0;
    start_op(16'h1234, 16'h4321, 1'b0);
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bsy++;
      @(negedge clk);
      n++;
      if (busy === 1'b1 && done === 1'b1) both++;
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 16", n);
    end
    vectors++;
    if (bsy !== 16) begin
      miscompares++;
      $display("FAIL basic_busy_cycles got %0d want 16", bsy);
    end
    vectors++;
    if (both !== 0) begin
      miscompares++;
      $display("FAIL basic_busy_and_done got %0d want 0", both);
    end
    vectors++;
    if ({Sum, Cout, Ofl} !== {16'h5555, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_result got %h/%b/%b want 5555/0/0",
               Sum, Cout, Ofl);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, Sum, Cout, Ofl} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_async got busy=%b done=%b sum=%h c=%b o=%b want 0",
               busy, done, Sum, Cout, Ofl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_carry();
    int n;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(n);
    vectors++;
    if ({Sum, Cout, Ofl} !== {16'h0000, 1'b1, 1'b0} || n !== 16) begin
      miscompares++;
      $display("FAIL carry_ffff got %h/%b/%b n=%0d want 0000/1/0 n=16",
               Sum, Cout, Ofl, n);
    end
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done(n);
    vectors++;
    if ({Sum, Cout, Ofl} !== {16'h8000, 1'b0, OFL_ON} || n !== 16) begin
      miscompares++;
      $display("FAIL ofl_7fff got %h/%b/%b n=%0d want 8000/0/%b n=16",
               Sum, Cout, Ofl, n, OFL_ON);
    end
  endtask

  task automatic test_cin_stable();
    int n, moved;
    n = 0; moved = 0;
    start_op(16'h0000, 16'hFFFF, 1'b1);
    while (done !== 1'b1 && n < 40) begin
      if (Sum !== 16'h8000 || Cout !== 1'b0) moved++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (moved !== 0) begin
      miscompares++;
      $display("FAIL stable_during_busy got %0d changes want 0", moved);
    end
    vectors++;
    if ({Sum, Cout, Ofl} !== {16'h0000, 1'b1, 1'b0} || n !== 16) begin
      miscompares++;
      $display("FAIL cin_path got %h/%b/%b n=%0d want 0000/1/0 n=16",
               Sum, Cout, Ofl, n);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [17:0] ve [3];
    int n;
    va[0] = 16'h0001; vb[0] = 16'h0002; ve[0] = {16'h0003, 1'b0, 1'b0};
    va[1] = 16'h1111; vb[1] = 16'h2222; ve[1] = {16'h3333, 1'b0, 1'b0};
    va[2] = 16'h8000; vb[2] = 16'h8000; ve[2] = {16'h0000, 1'b1, OFL_ON};
    @(negedge clk);
    start = 1'b1; Cin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      A = va[k]; B = vb[k];
      @(negedge clk);
      wait_done(n);
      vectors++;
      if (n + 1 !== 17) begin
        miscompares++;
        $display("FAIL b2b_period[%0d] got %0d want 17", k, n + 1);
      end
      vectors++;
      if ({Sum, Cout, Ofl} !== ve[k]) begin
        miscompares++;
        $display("FAIL b2b_result[%0d] got %h/%b/%b want %h/%b/%b", k,
                 Sum, Cout, Ofl, ve[k][17:2], ve[k][1], ve[k][0]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_stop got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_ignore();
    int n;
    start_op(16'h0100, 16'h0200, 1'b0);
    repeat (5) @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    vectors++;
    if ({Sum, Cout} !== {16'h0300, 1'b0} || n !== 10) begin
      miscompares++;
      $display("FAIL ignore_midrun got %h/%b n=%0d want 0300/0 n=10",
               Sum, Cout, n);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL ignore_no_rerun got busy=%b done=%b want 0/0",
               busy, done);
    end
  endtask

  task automatic test_abort();
    int n, pulses;
    pulses = 0;
    start_op(16'h00FF, 16'h0001, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, Sum, Cout, Ofl} !== 19'd0) begin
      miscompares++;
      $display("FAIL abort_clear got busy=%b done=%b sum=%h c=%b o=%b want 0",
               busy, done, Sum, Cout, Ofl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done got %0d active cycles want 0", pulses);
    end
    start_op(16'h00FF, 16'h0001, 1'b0);
    wait_done(n);
    vectors++;
    if ({Sum, Cout, Ofl} !== {16'h0100, 1'b0, 1'b0} || n !== 16) begin
      miscompares++;
      $display("FAIL abort_restart got %h/%b/%b n=%0d want 0100/0/0 n=16",
               Sum, Cout, Ofl, n);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_reset();
    test_carry();
    test_cin_stable();
    test_back_to_back();
    test_ignore();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
